// File: rtl/bin_bram_pkg.sv
// Shared definitions for the xy_bin RAM and its clients (tracer, scan-out, arbiter).
// The bin code width, address width and frame geometry live here so every client agrees on them.
package bin_bram_pkg;

    localparam int BIN_W  = 3;
    localparam int ADDR_W = 19;
    localparam int DEPTH  = 307200;
    localparam int H_RES  = 640;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oor;
    } rd_tag_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return ({13'd0, addr} < depth);
    endfunction

endpackage

// File: rtl/bin_rd_tag_pipe.sv
// Fixed-depth shift register carrying one read tag per cycle.
// Clearing on reset discards every read still in flight.
module bin_rd_tag_pipe
    import bin_bram_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [STAGES];

    // Shift tags toward the output stage, one stage per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[STAGES-1];

endmodule

// File: rtl/bin_bram_arbiter.sv
// Single-port xy_bin RAM arbiter: tracer (A, read/write) vs display scan-out (B, read only).
// B wins conflicts unless A has lost STARVE_LIMIT of them in a row.
module bin_bram_arbiter
    import bin_bram_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int DEPTH        = bin_bram_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [BIN_W-1:0]  a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [BIN_W-1:0]  a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [BIN_W-1:0]  b_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [BIN_W-1:0]  bram_din,
    input  logic [BIN_W-1:0]  bram_dout
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0]        r_starve_cnt;
    logic              r_bram_en;
    logic              r_bram_we;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [BIN_W-1:0]  r_bram_din;
    logic [BIN_W-1:0]  r_a_rdata;
    logic [BIN_W-1:0]  r_b_rdata;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_a_in_range;
    logic              w_b_in_range;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;
    logic [BIN_W-1:0]  w_rdata;
    logic              w_a_rvalid;
    logic              w_b_rvalid;

    assign w_a_in_range = addr_in_range(a_addr, DEPTH);
    assign w_b_in_range = addr_in_range(b_addr, DEPTH);

    // Grant decision; gated by reset so no command is accepted while reset is held
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!reset_n) begin
            w_a_gnt = 1'b0;
            w_b_gnt = 1'b0;
        end else if (a_req && b_req) begin
            if (r_starve_cnt == STARVE_MAX) begin
                w_a_gnt = 1'b1;
            end else begin
                w_b_gnt = 1'b1;
            end
        end else if (a_req) begin
            w_a_gnt = 1'b1;
        end else if (b_req) begin
            w_b_gnt = 1'b1;
        end else begin
            w_a_gnt = 1'b0;
            w_b_gnt = 1'b0;
        end
    end

    // Count conflicts A has lost; saturates so A is guaranteed the next conflict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 8'd0;
        end else if (w_a_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if (a_req && w_b_gnt && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Register the winning command onto the RAM port; out-of-range commands never enable the RAM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else if (w_a_gnt) begin
            r_bram_en   <= w_a_in_range;
            r_bram_we   <= a_we & w_a_in_range;
            r_bram_addr <= a_addr;
            r_bram_din  <= a_wdata;
        end else if (w_b_gnt) begin
            r_bram_en   <= w_b_in_range;
            r_bram_we   <= 1'b0;
            r_bram_addr <= b_addr;
        end else begin
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
        end
    end

    // Build the tag for this cycle's grant; writes and idle cycles push an empty tag
    always_comb begin
        w_tag_in = '0;
        if (w_a_gnt) begin
            w_tag_in.valid = ~a_we;
            w_tag_in.owner = OWN_A;
            w_tag_in.oor   = ~w_a_in_range;
        end else if (w_b_gnt) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.owner = OWN_B;
            w_tag_in.oor   = ~w_b_in_range;
        end else begin
            w_tag_in = '0;
        end
    end

    // One stage per cycle from grant to RAM output: issue cycle plus READ_LATENCY
    bin_rd_tag_pipe #(
        .STAGES (READ_LATENCY + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (reset_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_rdata    = w_tag_out.oor ? 3'd0 : bram_dout;
    assign w_a_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_A);
    assign w_b_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_B);

    // Remember the last delivered word so rdata holds between responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_rdata <= w_a_rvalid ? w_rdata : r_a_rdata;
            r_b_rdata <= w_b_rvalid ? w_rdata : r_b_rdata;
        end
    end

    assign a_gnt     = w_a_gnt;
    assign b_gnt     = w_b_gnt;
    assign a_rvalid  = w_a_rvalid;
    assign b_rvalid  = w_b_rvalid;
    assign a_rdata   = w_a_rvalid ? w_rdata : r_a_rdata;
    assign b_rdata   = w_b_rvalid ? w_rdata : r_b_rdata;
    assign bram_en   = r_bram_en;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;

endmodule

// File: tb/tb_bin_bram_arbiter.sv
// Directed bench for bin_bram_arbiter with a behavioural 2-cycle write-first RAM.
module tb_bin_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, b_req;
    logic [18:0] a_addr, b_addr;
    logic [2:0]  a_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [2:0]  a_rdata, b_rdata;
    logic        bram_en, bram_we;
    logic [18:0] bram_addr;
    logic [2:0]  bram_din, bram_dout;

    int total = 0;
    int bad   = 0;
    int we_count = 0;

    logic [2:0] mem [0:307199];
    logic [2:0] d1 = 3'd0;
    logic [2:0] d2 = 3'd0;

    always #5 clk = ~clk;

    bin_bram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // RAM model: write-first, data visible two cycles after the enable cycle
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[int'(bram_addr)] <= bram_din;
                we_count <= we_count + 1;
                d1 <= bram_din;
            end else begin
                d1 <= mem[int'(bram_addr)];
            end
        end
        d2 <= d1;
    end
    assign bram_dout = d2;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_req = 1'b0;
        b_req = 1'b0;
        a_we  = 1'b0;
        for (int i = 0; i < n; i++) nxt();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0;
        a_addr = 19'd5; b_addr = 19'd6; a_wdata = 3'd7;
        for (int i = 0; i < 3; i++) nxt();
        #2;
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, bram_en, bram_we, bram_addr, bram_din} !== 34'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, bram_en, bram_we, bram_addr, bram_din});
        end
        nxt();
        reset_n = 1'b1;
        #2;
        total++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            bad++;
            $display("FAIL reset_first_grant got a/b=%b%b want 01", a_gnt, b_gnt);
        end
        idle(6);
    endtask

    task automatic test_single_read();
        nxt();
        a_req = 1'b1; a_we = 1'b0; a_addr = 19'd1000;
        #2;
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL single_gnt got a/b=%b%b want 10", a_gnt, b_gnt);
        end
        nxt();
        a_req = 1'b0;
        #2;
        total++;
        if ({bram_en, bram_we, bram_addr} !== {1'b1, 1'b0, 19'd1000}) begin
            bad++;
            $display("FAIL single_issue got en=%b we=%b addr=%0d want 1 0 1000", bram_en, bram_we, bram_addr);
        end
        nxt();
        #2;
        total++;
        if (a_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_early got a_rvalid=%b want 0", a_rvalid);
        end
        nxt();
        #2;
        total++;
        if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 3'd5, 1'b0}) begin
            bad++;
            $display("FAIL single_resp got rv=%b rd=%0d brv=%b want 1 5 0", a_rvalid, a_rdata, b_rvalid);
        end
        nxt();
        #2;
        total++;
        if ({a_rvalid, a_rdata} !== {1'b0, 3'd5}) begin
            bad++;
            $display("FAIL single_hold got rv=%b rd=%0d want 0 5", a_rvalid, a_rdata);
        end
        idle(4);
    endtask

    task automatic test_starvation();
        logic [1:0] exp;
        nxt();
        a_req = 1'b1; a_we = 1'b0; a_addr = 19'd10;
        b_req = 1'b1; b_addr = 19'd20;
        for (int i = 0; i < 18; i++) begin
            #2;
            exp = ((i % 9) == 8) ? 2'b10 : 2'b01;
            total++;
            if ({a_gnt, b_gnt} !== exp) begin
                bad++;
                $display("FAIL starve_c%0d got a/b=%b%b want %b", i, a_gnt, b_gnt, exp);
            end
            nxt();
        end
        idle(6);
    endtask

    task automatic test_write_read();
        int wc0;
        wc0 = we_count;
        nxt();
        a_req = 1'b1; a_we = 1'b1; a_addr = 19'd640; a_wdata = 3'd3;
        #2;
        total++;
        if (a_gnt !== 1'b1) begin
            bad++;
            $display("FAIL wr_gnt got a_gnt=%b want 1", a_gnt);
        end
        nxt();
        a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b1; b_addr = 19'd640;
        #2;
        total++;
        if ({b_gnt, bram_en, bram_we, bram_din} !== {1'b1, 1'b1, 1'b1, 3'd3}) begin
            bad++;
            $display("FAIL wr_issue got gnt=%b en=%b we=%b din=%0d want 1 1 1 3", b_gnt, bram_en, bram_we, bram_din);
        end
        nxt();
        b_req = 1'b0;
        #2;
        total++;
        if ({bram_en, bram_we, bram_addr} !== {1'b1, 1'b0, 19'd640}) begin
            bad++;
            $display("FAIL rd_issue got en=%b we=%b addr=%0d want 1 0 640", bram_en, bram_we, bram_addr);
        end
        nxt();
        #2;
        total++;
        if ({bram_en, b_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL wr_idle got en=%b brv=%b want 0 0", bram_en, b_rvalid);
        end
        nxt();
        #2;
        total++;
        if ({b_rvalid, b_rdata, a_rvalid} !== {1'b1, 3'd3, 1'b0}) begin
            bad++;
            $display("FAIL wr_rd_data got rv=%b rd=%0d arv=%b want 1 3 0", b_rvalid, b_rdata, a_rvalid);
        end
        total++;
        if (we_count - wc0 !== 1) begin
            bad++;
            $display("FAIL wr_count got %0d writes want 1", we_count - wc0);
        end
        idle(4);
    endtask

    task automatic test_out_of_range();
        int wc0;
        logic en_seen;
        wc0 = we_count;
        en_seen = 1'b0;
        nxt();
        a_req = 1'b1; a_we = 1'b0; a_addr = 19'd307200;
        #2;
        total++;
        if (a_gnt !== 1'b1) begin
            bad++;
            $display("FAIL oor_gnt got a_gnt=%b want 1", a_gnt);
        end
        nxt();
        a_req = 1'b0;
        #2;
        en_seen = en_seen | bram_en;
        nxt();
        #2;
        en_seen = en_seen | bram_en;
        total++;
        if (en_seen !== 1'b0) begin
            bad++;
            $display("FAIL oor_en got en=%b want 0", en_seen);
        end
        nxt();
        #2;
        total++;
        if ({a_rvalid, a_rdata} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL oor_resp got rv=%b rd=%0d want 1 0", a_rvalid, a_rdata);
        end
        nxt();
        a_req = 1'b1; a_we = 1'b1; a_wdata = 3'd7;
        #2;
        total++;
        if (a_gnt !== 1'b1) begin
            bad++;
            $display("FAIL oor_wr_gnt got a_gnt=%b want 1", a_gnt);
        end
        nxt();
        a_req = 1'b0; a_we = 1'b0;
        #2;
        total++;
        if ({bram_en, bram_we} !== 2'b00) begin
            bad++;
            $display("FAIL oor_wr_issue got en=%b we=%b want 0 0", bram_en, bram_we);
        end
        idle(4);
        total++;
        if (we_count !== wc0) begin
            bad++;
            $display("FAIL oor_wr_count got %0d writes want 0", we_count - wc0);
        end
    endtask

    task automatic test_mid_reset();
        logic rv_seen;
        rv_seen = 1'b0;
        nxt();
        b_req = 1'b1; b_addr = 19'd2000;
        #2;
        total++;
        if (b_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_gnt got b_gnt=%b want 1", b_gnt);
        end
        nxt();
        b_req = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            rv_seen = rv_seen | b_rvalid;
            if (i == 1) begin
                nxt();
                reset_n = 1'b1;
            end else begin
                nxt();
            end
        end
        total++;
        if (rv_seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_dropped got b_rvalid seen=%b want 0", rv_seen);
        end
        b_req = 1'b1; b_addr = 19'd2000;
        #2;
        total++;
        if (b_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_regnt got b_gnt=%b want 1", b_gnt);
        end
        nxt();
        b_req = 1'b0;
        nxt();
        #2;
        total++;
        if (b_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL mid_early got b_rvalid=%b want 0", b_rvalid);
        end
        nxt();
        #2;
        total++;
        if ({b_rvalid, b_rdata} !== {1'b1, 3'd6}) begin
            bad++;
            $display("FAIL mid_resp got rv=%b rd=%0d want 1 6", b_rvalid, b_rdata);
        end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 307200; i++) mem[i] = 3'd0;
        mem[1000] = 3'd5;
        mem[2000] = 3'd6;
        mem[10]   = 3'd2;
        mem[20]   = 3'd4;
        test_reset();
        test_single_read();
        test_starvation();
        test_write_read();
        test_out_of_range();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
